alu_unit: RTL and testbench

- Registered integer ALU for the weasel datapath.
- Takes two Width-bit operands and an alu_operation_e opcode, and produces a result plus status flags (Z/N/C/V) one clock later.
- Sits between the register-file read stage and write-back; out_valid qualifies result and flags.

---
 rtl/alu_unit_if.sv | 28 ++
 rtl/alu_unit.sv | 133 +++++++++++++
 tb/tb_alu_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/alu_unit_if.sv
// Operand/result bundle for the weasel registered ALU.
// master drives operands and op; slave returns result and flags.
interface alu_unit_if #(
  parameter int Width = 16
);
  logic [Width-1:0] a;
  logic [Width-1:0] b;
  logic [3:0]       op;
  logic             in_valid;
  logic [Width-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic             out_valid;

  modport master (
    output a, b, op, in_valid,
    input  result, flag_z, flag_n,
    input  flag_c, flag_v, out_valid
  );

  modport slave (
    input  a, b, op, in_valid,
    output result, flag_z, flag_n,
    output flag_c, flag_v, out_valid
  );
endinterface

// File: rtl/alu_unit.sv
// Registered integer ALU for the weasel datapath.
// One op per cycle; result and Z/N/C/V appear one edge later.
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_NEG = 4'd6,
    OP_LSL = 4'd7,
    OP_LSR = 4'd8,
    OP_ASR = 4'd9
  } alu_operation_e;
endpackage

module alu_unit
  import alu_pkg::*;
#(
  parameter int Width = 16
) (
  input  logic       clk,
  input  logic       rst,
  alu_unit_if.slave  bus
);

  localparam int Msb = Width - 1;
  localparam logic [Width-1:0] MinNeg =
    {1'b1, {(Width-1){1'b0}}};

  logic [Width-1:0]   a;
  logic [Width-1:0]   b;
  logic [Width:0]     sum;
  logic [Width-1:0]   diff;
  logic [2*Width-1:0] shl;
  logic [2*Width-1:0] shr;
  logic [2*Width-1:0] sar;
  logic               big;

  logic [Width-1:0]   res;
  logic               c;
  logic               v;

  assign a = bus.a;
  assign b = bus.b;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = a - b;
  assign big  = {1'b0, b} >= (Width+1)'(Width);

  // Double-width shifts keep the last bit shifted out
  // sitting right next to the result field.
  assign shl = {{Width{1'b0}}, a} << b;
  assign shr = {a, {Width{1'b0}}} >> b;
  assign sar = $signed({a, {Width{1'b0}}}) >>> b;

  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    unique case (bus.op)
      OP_ADD: begin
        res = sum[Width-1:0];
        c   = sum[Width];
        v   = (a[Msb] == b[Msb]) &&
              (res[Msb] != a[Msb]);
      end
      OP_SUB: begin
        res = diff;
        c   = a >= b;
        v   = (a[Msb] != b[Msb]) &&
              (res[Msb] != a[Msb]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_NEG: begin
        res = (~a) + 1'b1;
        c   = a == '0;
        v   = a == MinNeg;
      end
      OP_LSL: begin
        if (!big) begin
          res = shl[Width-1:0];
          c   = shl[Width];
        end
      end
      OP_LSR: begin
        if (!big) begin
          res = shr[2*Width-1:Width];
          c   = shr[Width-1];
        end
      end
      OP_ASR: begin
        if (big) begin
          res = {Width{a[Msb]}};
          c   = a[Msb];
        end else begin
          res = sar[2*Width-1:Width];
          c   = sar[Width-1];
        end
      end
      default: begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result    <= '0;
      bus.flag_z    <= 1'b0;
      bus.flag_n    <= 1'b0;
      bus.flag_c    <= 1'b0;
      bus.flag_v    <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.result <= res;
        bus.flag_z <= res == '0;
        bus.flag_n <= res[Msb];
        bus.flag_c <= c;
        bus.flag_v <= v;
      end
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit at Width=4.
// Expected results and flags are hand-computed.
module tb_alu_unit;
  import alu_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  alu_unit_if #(.Width(W)) bus ();

  alu_unit #(.Width(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {bus.flag_z, bus.flag_n,
            bus.flag_c, bus.flag_v};
  endfunction

  // flg is {Z,N,C,V}
  task automatic run_op(
    input string        tag,
    input logic [3:0]   op,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [W-1:0] res,
    input logic [3:0]   flg
  );
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    check({tag, ".res"}, 32'(bus.result), 32'(res));
    check({tag, ".flg"}, 32'(flags()), 32'(flg));
    check({tag, ".vld"}, 32'(bus.out_valid), 32'd1);
  endtask

  initial begin
    bus.a        = 4'b0101;
    bus.b        = 4'b0011;
    bus.op       = OP_ADD;
    bus.in_valid = 1'b1;
    rst          = 1'b1;

    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("rst.res", 32'(bus.result), 32'd0);
      check("rst.flg", 32'(flags()), 32'd0);
      check("rst.vld", 32'(bus.out_valid), 32'd0);
    end
    rst = 1'b0;

    run_op("add0",  OP_ADD, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    run_op("or",    OP_OR,  4'b0010, 4'b0001, 4'b0011, 4'b0000);
    run_op("and",   OP_AND, 4'b0010, 4'b0001, 4'b0000, 4'b1000);
    run_op("xor",   OP_XOR, 4'b0010, 4'b0011, 4'b0001, 4'b0000);
    run_op("not",   OP_NOT, 4'b0010, 4'b0011, 4'b1101, 4'b0100);
    run_op("neg",   OP_NEG, 4'b0010, 4'b0011, 4'b1110, 4'b0100);

    run_op("asr1",  OP_ASR, 4'b1010, 4'b0001, 4'b1101, 4'b0100);
    run_op("lsl1",  OP_LSL, 4'b1010, 4'b0001, 4'b0100, 4'b0010);
    run_op("asr5",  OP_ASR, 4'b1010, 4'b0101, 4'b1111, 4'b0110);
    run_op("lsr4",  OP_LSR, 4'b1010, 4'b0100, 4'b0000, 4'b1000);
    run_op("lsr1",  OP_LSR, 4'b1010, 4'b0001, 4'b0101, 4'b0000);
    run_op("lsr3",  OP_LSR, 4'b1010, 4'b0011, 4'b0001, 4'b0000);
    run_op("lsl0",  OP_LSL, 4'b0011, 4'b0000, 4'b0011, 4'b0000);
    run_op("lsl3a", OP_LSL, 4'b0101, 4'b0011, 4'b1000, 4'b0100);
    run_op("lsl3b", OP_LSL, 4'b0110, 4'b0011, 4'b0000, 4'b1010);
    run_op("lsl4",  OP_LSL, 4'b1010, 4'b0100, 4'b0000, 4'b1000);
    run_op("asr7",  OP_ASR, 4'b0110, 4'b0111, 4'b0000, 4'b1000);
    run_op("asr0",  OP_ASR, 4'b1001, 4'b0000, 4'b1001, 4'b0100);

    run_op("addv",  OP_ADD, 4'b0111, 4'b0001, 4'b1000, 4'b0101);
    run_op("addc",  OP_ADD, 4'b1111, 4'b0001, 4'b0000, 4'b1010);
    run_op("sub_b", OP_SUB, 4'b0011, 4'b0101, 4'b1110, 4'b0100);
    run_op("sub_c", OP_SUB, 4'b0101, 4'b0011, 4'b0010, 4'b0010);
    run_op("sub_v", OP_SUB, 4'b1000, 4'b0001, 4'b0111, 4'b0011);
    run_op("negmn", OP_NEG, 4'b1000, 4'b0000, 4'b1000, 4'b0101);
    run_op("neg0",  OP_NEG, 4'b0000, 4'b0110, 4'b0000, 4'b1010);

    run_op("rsv12", 4'd12,  4'b0101, 4'b0011, 4'b0000, 4'b1000);
    run_op("rsv15", 4'd15,  4'b1111, 4'b1111, 4'b0000, 4'b1000);
    run_op("last",  OP_XOR, 4'b1100, 4'b0101, 4'b1001, 4'b0100);

    bus.in_valid = 1'b0;
    bus.op       = OP_ADD;
    bus.a        = 4'b0001;
    bus.b        = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("idle.res", 32'(bus.result), 32'h9);
      check("idle.flg", 32'(flags()), 32'h4);
      check("idle.vld", 32'(bus.out_valid), 32'd0);
    end

    run_op("resume", OP_ADD, 4'b0001, 4'b0001, 4'b0010, 4'b0000);

    bus.in_valid = 1'b1;
    rst          = 1'b1;
    @(posedge clk);
    #1;
    check("rst2.res", 32'(bus.result), 32'd0);
    check("rst2.vld", 32'(bus.out_valid), 32'd0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
